// File: rtl/timer_counter_8bit_pkg.sv
// Shared constants and types for the 8-bit APB timer/counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: bus widths, register addresses, TCR/TSR bit positions, address helper.
package timer_counter_8bit_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 3;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam addr_t ADDR_TDR  = 3'b010;
  localparam addr_t ADDR_TCR  = 3'b011;
  localparam addr_t ADDR_TCNT = 3'b100;
  localparam addr_t ADDR_TSR  = 3'b101;

  // TCR bit positions
  localparam int TCR_LOAD_BIT = 7;
  localparam int TCR_DIR_BIT  = 5;
  localparam int TCR_EN_BIT   = 4;
  localparam int TCR_CKS_MSB  = 1;
  localparam int TCR_CKS_LSB  = 0;

  // TSR bit positions
  localparam int TSR_OVF_BIT = 0;
  localparam int TSR_UDF_BIT = 1;

  // Writable TCR bits; reserved bits [6] and [3:2] always store 0.
  localparam data_t TCR_WR_MASK = data_t'((1 << TCR_LOAD_BIT) | (1 << TCR_DIR_BIT) |
                                          (1 << TCR_EN_BIT) | (1 << TCR_CKS_MSB) |
                                          (1 << TCR_CKS_LSB));

  function automatic logic addr_mapped(addr_t a);
    return (a == ADDR_TDR) || (a == ADDR_TCR) || (a == ADDR_TCNT) || (a == ADDR_TSR);
  endfunction

endpackage

// File: rtl/timer_counter_8bit_if.sv
// APB-style register bus bundle for the timer/counter.
// Latency: n/a (wires only).
// Backpressure: none; slave completes every access phase with pready.
// master drives psel/penable/pwrite/paddr/pwdata; slave returns prdata/pready/pslverr.
interface timer_counter_8bit_if;
  import timer_counter_8bit_pkg::*;

  logic  psel;
  logic  penable;
  logic  pwrite;
  addr_t paddr;
  data_t pwdata;
  data_t prdata;
  logic  pready;
  logic  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/timer_counter_8bit_prescaler.sv
// Free-running 4-bit prescaler producing a one-cycle tick every 2^(cks+1) clocks.
// Latency: tick is combinational from the registered count.
// Backpressure: none; never stalls, cks changes do not reset the count.
// Ports: pclk, preset (async active-high), cks[1:0] divide select, tick out.
module prescaler
  import timer_counter_8bit_pkg::*;
(
  input  logic       pclk,
  input  logic       preset,
  input  logic [1:0] cks,
  output logic       tick
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic [3:0] mask;

  always_comb begin
    cnt_d = cnt_q + 4'd1;
    // Low (cks+1) bits all ones marks the last cycle of each divide period.
    mask  = 4'((5'd2 << cks) - 5'd1);
    tick  = ((cnt_q & mask) == mask);
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_counter_8bit.sv
// 8-bit up/down timer with reload, sticky wrap flags and an APB register port.
// Latency: zero-wait-state bus (pready = psel & penable); writes land on the access edge.
// Backpressure: none; optional macro TMR_SLVERR_EN flags unmapped/TCNT-write accesses via pslverr.
// Ports: pclk, preset (async active-high), apb (slave modport), TMR_OVF, TMR_UDF.
module timer_counter_8bit
  import timer_counter_8bit_pkg::*;
(
  input  logic                 pclk,
  input  logic                 preset,
  timer_counter_8bit_if.slave  apb,
  output logic                 TMR_OVF,
  output logic                 TMR_UDF
);

  data_t tdr_q, tdr_d;
  data_t tcr_q, tcr_d;
  data_t tcnt_q, tcnt_d;
  logic  ovf_q, ovf_d;
  logic  udf_q, udf_d;

  logic  tick;
  logic  access;
  logic  wr_en;
  logic  ovf_set;
  logic  udf_set;

  prescaler u_prescaler (
    .pclk   (pclk),
    .preset (preset),
    .cks    (tcr_q[TCR_CKS_MSB:TCR_CKS_LSB]),
    .tick   (tick)
  );

  assign access     = apb.psel & apb.penable;
  assign apb.pready = access;

`ifdef TMR_SLVERR_EN
  logic bad_access;
  assign bad_access  = !addr_mapped(apb.paddr) || (apb.pwrite && (apb.paddr == ADDR_TCNT));
  assign apb.pslverr = access & bad_access;
`else
  assign apb.pslverr = 1'b0;
`endif

  // An erroring access never commits.
  assign wr_en = access & apb.pwrite & ~apb.pslverr;

  always_comb begin
    tdr_d   = tdr_q;
    tcr_d   = tcr_q;
    tcnt_d  = tcnt_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    ovf_set = 1'b0;
    udf_set = 1'b0;

    // LOAD wins over counting; counting uses register values before this edge's write.
    if (tcr_q[TCR_LOAD_BIT]) begin
      tcnt_d = tdr_q;
    end else if (tcr_q[TCR_EN_BIT] && tick) begin
      if (tcr_q[TCR_DIR_BIT]) begin
        tcnt_d  = tcnt_q - 8'd1;
        udf_set = (tcnt_q == 8'h00);
      end else begin
        tcnt_d  = tcnt_q + 8'd1;
        ovf_set = (tcnt_q == 8'hFF);
      end
    end

    if (wr_en) begin
      case (apb.paddr)
        ADDR_TDR: tdr_d = apb.pwdata;
        ADDR_TCR: tcr_d = apb.pwdata & TCR_WR_MASK;
        ADDR_TSR: begin
          if (apb.pwdata[TSR_OVF_BIT]) ovf_d = 1'b0;
          if (apb.pwdata[TSR_UDF_BIT]) udf_d = 1'b0;
        end
        default: ;
      endcase
    end

    // A wrap on the same edge as a W1C keeps the flag set.
    if (ovf_set) ovf_d = 1'b1;
    if (udf_set) udf_d = 1'b1;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tdr_q  <= '0;
      tcr_q  <= '0;
      tcnt_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      tdr_q  <= tdr_d;
      tcr_q  <= tcr_d;
      tcnt_q <= tcnt_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  always_comb begin
    apb.prdata = '0;
    if (apb.psel && !apb.pwrite) begin
      case (apb.paddr)
        ADDR_TDR:  apb.prdata = tdr_q;
        ADDR_TCR:  apb.prdata = tcr_q;
        ADDR_TCNT: apb.prdata = tcnt_q;
        ADDR_TSR:  apb.prdata = {6'b0, udf_q, ovf_q};
        default:   apb.prdata = '0;
      endcase
    end
  end

  assign TMR_OVF = ovf_q;
  assign TMR_UDF = udf_q;

endmodule

// File: tb/tb_timer_counter_8bit.sv
// Self-checking bench for timer_counter_8bit: directed scenarios plus random register traffic.
// Every cycle the bus outputs and flags are compared against a cycle-count reference model.
// Directed checks compare observed count sequences and flags against fixed expected values.
module tb_timer_counter_8bit;

  logic pclk = 1'b0;
  logic preset;
  logic tmr_ovf;
  logic tmr_udf;

  timer_counter_8bit_if bus();

  timer_counter_8bit dut (
    .pclk    (pclk),
    .preset  (preset),
    .apb     (bus),
    .TMR_OVF (tmr_ovf),
    .TMR_UDF (tmr_udf)
  );

  always #5 pclk = ~pclk;

`ifdef TMR_SLVERR_EN
  localparam bit SLVERR_ON = 1'b1;
`else
  localparam bit SLVERR_ON = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  m_tdr, m_tcr, m_tcnt;
  logic        m_ovf, m_udf;
  int unsigned m_edges;

  // Directed-observation records
  logic [7:0] seen[$];
  int         seen_at[$];
  logic       seen_ovf[$];
  logic       seen_udf[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [2:0] a);
    case (a)
      3'd2:    return m_tdr;
      3'd3:    return m_tcr;
      3'd4:    return m_tcnt;
      3'd5:    return {6'b0, m_udf, m_ovf};
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic m_err();
    if (!SLVERR_ON) return 1'b0;
    return bus.psel && bus.penable &&
           (!(bus.paddr inside {3'd2, 3'd3, 3'd4, 3'd5}) || (bus.pwrite && bus.paddr == 3'd4));
  endfunction

  task automatic model_reset();
    m_tdr = 0; m_tcr = 0; m_tcnt = 0; m_ovf = 0; m_udf = 0; m_edges = 0;
  endtask

  // One rising edge of behaviour, using the bus inputs currently applied.
  task automatic model_step();
    int  k, div;
    bit  tick, wr, set_o, set_u;
    if (preset) begin
      model_reset();
      return;
    end
    k     = int'(m_tcr[1:0]);
    div   = 1 << (k + 1);
    tick  = ((m_edges % div) == div - 1);
    wr    = bus.psel && bus.penable && bus.pwrite && !m_err();
    set_o = 0;
    set_u = 0;
    if (m_tcr[7]) begin
      m_tcnt = m_tdr;
    end else if (m_tcr[4] && tick) begin
      if (m_tcr[5]) begin
        set_u  = (m_tcnt == 0);
        m_tcnt = 8'((int'(m_tcnt) + 255) % 256);
      end else begin
        set_o  = (m_tcnt == 255);
        m_tcnt = 8'((int'(m_tcnt) + 1) % 256);
      end
    end
    if (wr) begin
      if (bus.paddr == 3'd2) m_tdr = bus.pwdata;
      if (bus.paddr == 3'd3) m_tcr = {bus.pwdata[7], 1'b0, bus.pwdata[5:4], 2'b00, bus.pwdata[1:0]};
      if (bus.paddr == 3'd5) begin
        if (bus.pwdata[0]) m_ovf = 0;
        if (bus.pwdata[1]) m_udf = 0;
      end
    end
    if (set_o) m_ovf = 1;
    if (set_u) m_udf = 1;
    m_edges++;
  endtask

  task automatic check_outputs();
    chk("pready",  8'(bus.pready),  8'(bus.psel && bus.penable));
    chk("prdata",  bus.prdata,      (bus.psel && !bus.pwrite) ? m_read(bus.paddr) : 8'h00);
    chk("pslverr", 8'(bus.pslverr), 8'(m_err()));
    chk("tmr_ovf", 8'(tmr_ovf),     8'(m_ovf));
    chk("tmr_udf", 8'(tmr_udf),     8'(m_udf));
  endtask

  task automatic tick_clk();
    #1;
    check_outputs();
    model_step();
    @(posedge pclk);
    #1;
  endtask

  task automatic bus_idle();
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
  endtask

  task automatic idle(input int n);
    bus_idle();
    repeat (n) tick_clk();
  endtask

  task automatic apb_write(input logic [2:0] a, input logic [7:0] d);
    bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = a; bus.pwdata = d;
    tick_clk();
    bus.penable = 1;
    tick_clk();
    bus_idle();
  endtask

  task automatic read_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    bus.psel = 1; bus.penable = 0; bus.pwrite = 0; bus.paddr = a;
    tick_clk();
    bus.penable = 1;
    #1;
    chk(tag, bus.prdata, exp);
    tick_clk();
    bus_idle();
  endtask

  // Hold a read of TCNT and record each new value, its cycle and the flags.
  task automatic watch_tcnt(input int n_vals, input int budget);
    seen.delete(); seen_at.delete(); seen_ovf.delete(); seen_udf.delete();
    bus.psel = 1; bus.penable = 1; bus.pwrite = 0; bus.paddr = 3'd4;
    #1;
    seen.push_back(bus.prdata); seen_at.push_back(0);
    seen_ovf.push_back(tmr_ovf); seen_udf.push_back(tmr_udf);
    for (int c = 1; c <= budget && seen.size() < n_vals; c++) begin
      tick_clk();
      if (bus.prdata !== seen[$]) begin
        seen.push_back(bus.prdata); seen_at.push_back(c);
        seen_ovf.push_back(tmr_ovf); seen_udf.push_back(tmr_udf);
      end
    end
    bus_idle();
  endtask

  initial begin
    logic [7:0] exp_dn[5];
    logic [7:0] exp_up[3];
    logic [7:0] held;
    int         hits;

    exp_dn[0] = 8'h03; exp_dn[1] = 8'h02; exp_dn[2] = 8'h01; exp_dn[3] = 8'h00; exp_dn[4] = 8'hFF;
    exp_up[0] = 8'hFE; exp_up[1] = 8'hFF; exp_up[2] = 8'h00;

    // Power-on reset
    preset = 1;
    bus_idle(); bus.paddr = 0; bus.pwdata = 0;
    model_reset();
    tick_clk();
    tick_clk();
    preset = 0;
    read_chk("rst_tdr", 3'd2, 8'h00);
    read_chk("rst_tcr", 3'd3, 8'h00);
    read_chk("rst_tcnt", 3'd4, 8'h00);
    read_chk("rst_tsr", 3'd5, 8'h00);

    // Up-count overflow at /2
    apb_write(3'd2, 8'hFE);
    apb_write(3'd3, 8'h80);
    apb_write(3'd3, 8'h10);
    watch_tcnt(3, 40);
    chk("up_nvals", 8'(seen.size()), 8'd3);
    if (seen.size() == 3) begin
      for (int i = 0; i < 3; i++) chk($sformatf("up_val%0d", i), seen[i], exp_up[i]);
      chk("up_gap", 8'(seen_at[2] - seen_at[1]), 8'd2);
      chk("up_ovf_before", 8'(seen_ovf[1]), 8'd0);
      chk("up_ovf_at_00", 8'(seen_ovf[2]), 8'd1);
    end

    // Down-count underflow at /16
    apb_write(3'd5, 8'h02);
    apb_write(3'd2, 8'h03);
    apb_write(3'd3, 8'hA3);
    apb_write(3'd3, 8'h33);
    watch_tcnt(5, 120);
    chk("dn_nvals", 8'(seen.size()), 8'd5);
    if (seen.size() == 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("dn_val%0d", i), seen[i], exp_dn[i]);
      for (int i = 2; i < 5; i++) chk($sformatf("dn_gap%0d", i), 8'(seen_at[i] - seen_at[i-1]), 8'd16);
      chk("dn_udf_before", 8'(seen_udf[3]), 8'd0);
      chk("dn_udf_at_ff", 8'(seen_udf[4]), 8'd1);
    end

    // Disable freezes count; W1C clears only UDF
    idle(10);
    apb_write(3'd3, 8'h23);
    held = m_tcnt;
    read_chk("frozen_a", 3'd4, held);
    idle(40);
    read_chk("frozen_b", 3'd4, held);
    apb_write(3'd5, 8'h02);
    #1;
    chk("clr_udf", 8'(tmr_udf), 8'd0);
    chk("keep_ovf", 8'(tmr_ovf), 8'd1);
    read_chk("tcr_reserved", 3'd3, 8'h23);

    // Underflow on the same edge as a held W1C
    apb_write(3'd2, 8'h00);
    apb_write(3'd3, 8'hA0);
    apb_write(3'd5, 8'h03);
    apb_write(3'd3, 8'h30);
    bus.psel = 1; bus.penable = 1; bus.pwrite = 1; bus.paddr = 3'd5; bus.pwdata = 8'h02;
    hits = 0;
    for (int c = 0; c < 8; c++) begin
      tick_clk();
      if (tmr_udf === 1'b1) hits++;
    end
    bus_idle();
    chk("collide_udf_hits", 8'(hits), 8'd1);

    // Unmapped address and TCNT write
    bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 3'd0; bus.pwdata = 8'hFF;
    tick_clk();
    bus.penable = 1;
    #1;
    chk("slverr_unmapped", 8'(bus.pslverr), 8'(SLVERR_ON));
    tick_clk();
    bus.paddr = 3'd4; bus.pwdata = 8'h55; bus.penable = 0;
    tick_clk();
    bus.penable = 1;
    #1;
    chk("slverr_tcnt_wr", 8'(bus.pslverr), 8'(SLVERR_ON));
    tick_clk();
    bus_idle();
    read_chk("err_tdr_kept", 3'd2, 8'h00);
    read_chk("err_tcr_kept", 3'd3, 8'h30);
    read_chk("unmapped_rd", 3'd7, 8'h00);

    // Random register traffic
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 3))
        0: apb_write(3'($urandom_range(0, 7)), 8'($urandom));
        1: apb_write(3'd3, 8'($urandom));
        2: begin
          bus.psel = 1; bus.penable = 0; bus.pwrite = 0; bus.paddr = 3'($urandom_range(0, 7));
          tick_clk();
          bus.penable = 1;
          tick_clk();
          bus_idle();
        end
        default: idle($urandom_range(1, 8));
      endcase
    end

    // Reset in the middle of counting
    apb_write(3'd5, 8'h03);
    apb_write(3'd2, 8'hFD);
    apb_write(3'd3, 8'h80);
    apb_write(3'd3, 8'h10);
    idle(12);
    chk("pre_rst_ovf", 8'(tmr_ovf), 8'd1);
    bus.psel = 1; bus.penable = 1; bus.pwrite = 0; bus.paddr = 3'd4;
    #2;
    preset = 1;
    model_reset();
    #1;
    chk("rst_async_ovf", 8'(tmr_ovf), 8'd0);
    chk("rst_async_udf", 8'(tmr_udf), 8'd0);
    chk("rst_async_prdata", bus.prdata, 8'h00);
    chk("rst_async_pslverr", 8'(bus.pslverr), 8'd0);
    tick_clk();
    preset = 0;
    bus_idle();
    read_chk("mid_rst_tdr", 3'd2, 8'h00);
    read_chk("mid_rst_tcr", 3'd3, 8'h00);
    read_chk("mid_rst_tcnt", 3'd4, 8'h00);
    read_chk("mid_rst_tsr", 3'd5, 8'h00);
    idle(20);
    read_chk("idle_after_rst", 3'd4, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
